ksa_mp_sequencer: RTL and testbench
===================================

Name: ksa_mp_sequencer

Overview:
Multi-precision add/subtract sequencer. It time-shares one N-bit ksa instance to compute a WORDS*N-bit sum one N-bit slice per cycle, least-significant slice first, chaining the carry through a register. It sits between a requester and the result consumer, with valid/ready handshakes on both sides. Typical use is 64-bit arithmetic on a 16-bit adder without building a 64-bit adder.

Parameters:
N, 16, width of the shared ksa datapath (one slice).
WORDS, 4, number of slices per operand (WORDS >= 1); total width W = N*WORDS.

Ports:
clk  input  1  system clock, rising-edge active.
reset  input  1  synchronous, active-low; sampled on the rising edge of clk.
in_valid  input  1  request valid.
in_ready  output  1  sequencer can accept a request.
in_a  input  N*WORDS  operand A.
in_b  input  N*WORDS  operand B.
in_cin  input  1  carry-in (add) or borrow-in (sub).
in_sub  input  1  1 = A - B - in_cin, 0 = A + B + in_cin.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
out_s  output  N*WORDS  result.
out_cout  output  1  final carry out of the top slice; for sub, 1 = no borrow.
out_ovf  output  1  two's-complement signed overflow of the W-bit result.
busy  output  1  state != IDLE.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (reset==0 at a rising edge): state <= IDLE; slice index, carry register and result register <= 0. After reset: in_ready=1, out_valid=0, out_s=0, out_cout=0, out_ovf=0, busy=0.
- Reset asserted mid-RUN or in DONE discards the transaction. No partial result is ever presented.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: capture a_reg=in_a; b_reg = in_sub ? ~in_b : in_b; carry_reg = in_sub ? ~in_cin : in_cin. Set idx=0 and go to RUN.
  - Inputs need not be held after acceptance.
- RUN:
  - in_ready=0.
  - Each cycle, ksa receives a=a_reg[idx*N +: N], b=b_reg[idx*N +: N], cin=carry_reg.
  - At the edge: s_reg[idx*N +: N] <= ksa.s; carry_reg <= ksa.cout; idx <= idx+1.
  - When idx==WORDS-1, also latch the overflow terms and go to DONE.
  - idx width is max(1,$clog2(WORDS)). No wrap is reachable.
- DONE:
  - out_valid=1; out_s=s_reg; out_cout=carry_reg.
  - out_ovf = (a_reg[W-1] == b_reg[W-1]) && (s_reg[W-1] != a_reg[W-1]), using the inverted B for sub.
  - Outputs are held stable while out_ready==0.
  - On out_ready: go to IDLE.
  - in_ready=0 in DONE. No same-cycle accept/complete overlap.
- Latency: request accepted at edge E; out_valid rises after edge E+WORDS (RUN occupies WORDS cycles). Best-case throughput is one transaction per WORDS+2 cycles.
- out_s, out_cout and out_ovf retain their last values in IDLE/RUN but are meaningful only when out_valid=1.
- in_valid while busy is ignored (in_ready=0). Requesters must hold in_valid until the handshake completes.
- WORDS==1: single RUN cycle, then behaviour is identical to a registered ksa.
- The ksa is purely combinational. The sequencer adds no pipeline stage inside the adder path.

Decomposition:
- Package ksa_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} ksa_seq_state_t.
  - Function for the idx width (max(1,$clog2(WORDS))).
- One sub-module: the existing ksa #(.N(N)), instantiated once.
- Slice mux, carry register and result register live in ksa_mp_sequencer.

Test Plan:
All cases use N=16, WORDS=4 unless stated.
1. Add: A=0xFFFF_FFFF_FFFF_FFFF, B=0x0000_0000_0000_0001, cin=0, sub=0 -> out_s=0, out_cout=1, out_ovf=0; out_valid rises exactly 4 cycles after the accept edge.
2. Sub: A=5, B=7, cin=0, sub=1 -> out_s=0xFFFF_FFFF_FFFF_FFFE, out_cout=0 (borrow), out_ovf=0. A=7, B=5 -> out_s=2, out_cout=1.
3. Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1, add -> out_s=0x8000_0000_0000_0000, out_ovf=1, out_cout=0. A=0x8000_0000_0000_0000, B=1, sub -> out_s=0x7FFF_FFFF_FFFF_FFFF, out_ovf=1.
4. Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_s/out_cout/out_ovf stable, in_ready=0. A concurrent in_valid with A=1, B=1 is not accepted. After out_ready=1, the next request yields out_s=2.
5. Reset mid-op: drop reset in RUN at idx=2 for one edge -> next cycle out_valid=0, in_ready=1, busy=0, out_s=0. A following A=3, B=4 add produces out_s=7, out_cout=0.
6. Random: 200 random add/sub vectors with random out_ready stalls, checked against a W+1-bit reference model. Repeat with WORDS=1 (latency 1 RUN cycle).

Source files
------------

// File: rtl/ksa_pkg.sv
// Shared types and helpers for the multi-precision ksa sequencer.
package ksa_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} ksa_seq_state_t;

  // Slice index width; a single-slice sequencer still keeps a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/ksa.sv
// Combinational N-bit Kogge-Stone adder with carry-in and carry-out.
module ksa #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  localparam int unsigned L = (N > 1) ? $clog2(N) : 0;

  logic [L:0][N-1:0] g;
  logic [L:0][N-1:0] p;
  logic [N:0]        c;

  always_comb begin
    g    = '0;
    p    = '0;
    c    = '0;
    g[0] = a & b;
    p[0] = a ^ b;
    for (int unsigned k = 0; k < L; k++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (i >= (32'd1 << k)) begin
          g[k+1][i] = g[k][i] | (p[k][i] & g[k][i-(32'd1 << k)]);
          p[k+1][i] = p[k][i] & p[k][i-(32'd1 << k)];
        end else begin
          g[k+1][i] = g[k][i];
          p[k+1][i] = p[k][i];
        end
      end
    end
    // Group generate/propagate from bit 0 lets cin fold in at the end.
    c[0] = cin;
    for (int unsigned i = 0; i < N; i++) begin
      c[i+1] = g[L][i] | (p[L][i] & cin);
    end
    s    = p[0] ^ c[N-1:0];
    cout = c[N];
  end

endmodule

// File: rtl/ksa_mp_sequencer.sv
// Multi-precision add/subtract: one shared N-bit ksa walks WORDS slices LSB first.
module ksa_mp_sequencer
  import ksa_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WORDS-1:0] in_a,
  input  logic [N*WORDS-1:0] in_b,
  input  logic               in_cin,
  input  logic               in_sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WORDS-1:0] out_s,
  output logic               out_cout,
  output logic               out_ovf,
  output logic               busy
);

  localparam int unsigned IW = idx_width(WORDS);

  ksa_seq_state_t            state_q;
  logic [IW-1:0]             idx_q;
  logic [WORDS-1:0][N-1:0]   a_q;
  logic [WORDS-1:0][N-1:0]   b_q;
  logic [WORDS-1:0][N-1:0]   s_q;
  logic                      carry_q;
  logic                      cout_q;
  logic                      ovf_q;

  logic [N-1:0]              a_sl;
  logic [N-1:0]              b_sl;
  logic [N-1:0]              sum;
  logic                      sum_cout;
  logic                      last;

  // Compare-based slice select keeps the index width legal for WORDS == 1.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int unsigned w = 0; w < WORDS; w++) begin
      if (idx_q == IW'(w)) begin
        a_sl = a_q[w];
        b_sl = b_q[w];
      end
    end
    last = (idx_q == IW'(WORDS - 1));
  end

  ksa #(.N(N)) u_ksa (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry_q),
    .s    (sum),
    .cout (sum_cout)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_sub ? ~in_b : in_b;
            carry_q <= in_cin ^ in_sub;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          for (int unsigned w = 0; w < WORDS; w++) begin
            if (idx_q == IW'(w)) s_q[w] <= sum;
          end
          carry_q <= sum_cout;
          idx_q   <= idx_q + IW'(1);
          if (last) begin
            cout_q  <= sum_cout;
            ovf_q   <= (a_q[WORDS-1][N-1] == b_q[WORDS-1][N-1]) &&
                       (sum[N-1] != a_q[WORDS-1][N-1]);
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_s     = s_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_ksa_mp_sequencer.sv
// Bench for ksa_mp_sequencer: directed scenarios plus scoreboarded random traffic (WORDS=4 and WORDS=1).
module tb_ksa_mp_sequencer;

  typedef struct packed {
    logic [63:0] s;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_cin, in_sub, out_ready;
  logic [63:0] in_a, in_b;
  logic        in_ready, out_valid, out_cout, out_ovf, busy;
  logic [63:0] out_s;

  logic        v1, c1, sub1, r1;
  logic [15:0] a1, b1;
  logic        ir1, ov1, co1, of1, bz1;
  logic [15:0] s1;

  exp_t q4[$];
  exp_t q1[$];
  exp_t e4, e1;
  int   checks = 0;
  int   fails  = 0;
  int   pops4  = 0;
  int   pops1  = 0;

  always #5 clk = ~clk;

  ksa_mp_sequencer #(.N(16), .WORDS(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
    .out_cout(out_cout), .out_ovf(out_ovf), .busy(busy)
  );

  ksa_mp_sequencer #(.N(16), .WORDS(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_ready(ir1),
    .in_a(a1), .in_b(b1), .in_cin(c1), .in_sub(sub1),
    .out_valid(ov1), .out_ready(r1), .out_s(s1),
    .out_cout(co1), .out_ovf(of1), .busy(bz1)
  );

  // Reference: exact integer arithmetic on w-bit operands in 65 bits.
  function automatic exp_t model(input int unsigned w, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub);
    logic [64:0] m, aa, bb, full;
    exp_t e;
    m    = (65'd1 << w) - 65'd1;
    aa   = {1'b0, a} & m;
    bb   = {1'b0, b} & m;
    full = sub ? (aa - bb - {64'd0, cin}) : (aa + bb + {64'd0, cin});
    e.s    = full[63:0] & m[63:0];
    e.cout = sub ? ~full[w] : full[w];
    e.ovf  = sub ? ((aa[w-1] != bb[w-1]) && (full[w-1] != aa[w-1]))
                 : ((aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]));
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      q4.delete();
    end else begin
      if (in_valid && in_ready) q4.push_back(model(64, in_a, in_b, in_cin, in_sub));
      if (out_valid && out_ready) begin
        checks++;
        pops4++;
        if (q4.size() == 0) begin
          fails++;
          $display("FAIL sb4_unexpected: result %h with no request outstanding", out_s);
        end else begin
          e4 = q4.pop_front();
          if ({out_s, out_cout, out_ovf} !== {e4.s, e4.cout, e4.ovf}) begin
            fails++;
            $display("FAIL sb4_result: got s=%h c=%b v=%b want s=%h c=%b v=%b",
                     out_s, out_cout, out_ovf, e4.s, e4.cout, e4.ovf);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      q1.delete();
    end else begin
      if (v1 && ir1) q1.push_back(model(16, {48'd0, a1}, {48'd0, b1}, c1, sub1));
      if (ov1 && r1) begin
        checks++;
        pops1++;
        if (q1.size() == 0) begin
          fails++;
          $display("FAIL sb1_unexpected: result %h with no request outstanding", s1);
        end else begin
          e1 = q1.pop_front();
          if ({s1, co1, of1} !== {e1.s[15:0], e1.cout, e1.ovf}) begin
            fails++;
            $display("FAIL sb1_result: got s=%h c=%b v=%b want s=%h c=%b v=%b",
                     s1, co1, of1, e1.s[15:0], e1.cout, e1.ovf);
          end
        end
      end
    end
  end

  // Issue one request from IDLE and wait (bounded) for out_valid with out_ready low.
  task automatic run_txn(input logic [63:0] a, input logic [63:0] b, input logic cin,
                         input logic sub, output int lat);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; out_ready = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
    in_cin = ~cin; in_sub = ~sub;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      checks++; fails++;
      $display("FAIL txn_timeout: out_valid=%b after %0d cycles, want 1", out_valid, lat);
    end
  endtask

  task automatic finish_txn();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
    v1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0; sub1 = 1'b0; r1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, out_s, out_cout, out_ovf, busy} !== {1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: rdy=%b val=%b s=%h c=%b v=%b busy=%b want 1 0 0 0 0 0",
               in_ready, out_valid, out_s, out_cout, out_ovf, busy);
    end
    checks++;
    if ({ir1, ov1, s1, bz1} !== {1'b1, 1'b0, 16'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state_w1: rdy=%b val=%b s=%h busy=%b want 1 0 0 0", ir1, ov1, s1, bz1);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int lat;
    run_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 4) begin fails++; $display("FAIL add_latency: got %0d want 4", lat); end
    checks++;
    if ({out_s, out_cout, out_ovf} !== {64'd0, 1'b1, 1'b0}) begin
      fails++; $display("FAIL add_wrap: got s=%h c=%b v=%b want 0 1 0", out_s, out_cout, out_ovf);
    end
    checks++;
    if ({in_ready, busy} !== 2'b01) begin
      fails++; $display("FAIL done_flags: got rdy=%b busy=%b want 0 1", in_ready, busy);
    end
    finish_txn();
  endtask

  task automatic test_sub();
    int lat;
    run_txn(64'd5, 64'd7, 1'b0, 1'b1, lat);
    checks++;
    if ({out_s, out_cout, out_ovf} !== {64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0}) begin
      fails++; $display("FAIL sub_borrow: got s=%h c=%b v=%b want fffffffffffffffe 0 0", out_s, out_cout, out_ovf);
    end
    finish_txn();
    run_txn(64'd7, 64'd5, 1'b0, 1'b1, lat);
    checks++;
    if ({out_s, out_cout} !== {64'd2, 1'b1}) begin
      fails++; $display("FAIL sub_noborrow: got s=%h c=%b want 2 1", out_s, out_cout);
    end
    finish_txn();
  endtask

  task automatic test_overflow();
    int lat;
    run_txn(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, lat);
    checks++;
    if ({out_s, out_cout, out_ovf} !== {64'h8000_0000_0000_0000, 1'b0, 1'b1}) begin
      fails++; $display("FAIL ovf_add: got s=%h c=%b v=%b want 8000000000000000 0 1", out_s, out_cout, out_ovf);
    end
    finish_txn();
    run_txn(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, lat);
    checks++;
    if ({out_s, out_cout, out_ovf} !== {64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1}) begin
      fails++; $display("FAIL ovf_sub: got s=%h c=%b v=%b want 7fffffffffffffff 1 1", out_s, out_cout, out_ovf);
    end
    finish_txn();
  endtask

  task automatic test_backpressure();
    int   lat;
    exp_t ex;
    ex = model(64, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0);
    run_txn(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, lat);
    in_a = 64'd1; in_b = 64'd1; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, out_s, out_cout, out_ovf} !== {1'b1, 1'b0, ex.s, ex.cout, ex.ovf}) begin
        fails++;
        $display("FAIL stall_hold[%0d]: got val=%b rdy=%b s=%h c=%b v=%b want 1 0 %h %b %b",
                 i, out_valid, in_ready, out_s, out_cout, out_ovf, ex.s, ex.cout, ex.ovf);
      end
    end
    in_valid = 1'b0;
    finish_txn();
    @(posedge clk); #1;
    checks++;
    if ({busy, in_ready} !== 2'b01) begin
      fails++; $display("FAIL stall_no_accept: got busy=%b rdy=%b want 0 1", busy, in_ready);
    end
    run_txn(64'd1, 64'd1, 1'b0, 1'b0, lat);
    checks++;
    if (out_s !== 64'd2) begin fails++; $display("FAIL after_stall: got s=%h want 2", out_s); end
    finish_txn();
  endtask

  task automatic test_reset_midop();
    int lat;
    in_a = 64'h0123_4567_89AB_CDEF; in_b = 64'h1111_2222_3333_4444;
    in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, out_valid} !== 2'b10) begin
      fails++; $display("FAIL midop_running: got busy=%b val=%b want 1 0", busy, out_valid);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    checks++;
    if ({out_valid, in_ready, busy, out_s, out_cout} !== {1'b0, 1'b1, 1'b0, 64'd0, 1'b0}) begin
      fails++;
      $display("FAIL midop_reset: got val=%b rdy=%b busy=%b s=%h c=%b want 0 1 0 0 0",
               out_valid, in_ready, busy, out_s, out_cout);
    end
    run_txn(64'd3, 64'd4, 1'b0, 1'b0, lat);
    checks++;
    if ({out_s, out_cout, lat} !== {64'd7, 1'b0, 32'd4}) begin
      fails++; $display("FAIL after_reset: got s=%h c=%b lat=%0d want 7 0 4", out_s, out_cout, lat);
    end
    finish_txn();
  endtask

  task automatic test_single_word();
    int lat;
    a1 = 16'hFFFF; b1 = 16'h0001; c1 = 1'b0; sub1 = 1'b0; r1 = 1'b0; v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0; a1 = 16'h5A5A; b1 = 16'hA5A5;
    lat = 0;
    while (!ov1 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++;
    if ({lat, s1, co1, of1} !== {32'd1, 16'd0, 1'b1, 1'b0}) begin
      fails++; $display("FAIL w1_add: got lat=%0d s=%h c=%b v=%b want 1 0 1 0", lat, s1, co1, of1);
    end
    r1 = 1'b1;
    @(posedge clk); #1;
    r1 = 1'b0;
  endtask

  task automatic test_random(input bit w1);
    int sent = 0;
    int cyc  = 0;
    int p0;
    bit hs;
    p0 = w1 ? pops1 : pops4;
    while (cyc < 20000 && (sent < 200 || (w1 ? v1 : in_valid) || (w1 ? q1.size() : q4.size()) != 0)) begin
      hs = w1 ? (v1 && ir1) : (in_valid && in_ready);
      @(posedge clk); #1;
      cyc++;
      if (hs) begin
        if (w1) v1 = 1'b0; else in_valid = 1'b0;
      end
      if (!(w1 ? v1 : in_valid) && sent < 200 && $urandom_range(0, 3) != 0) begin
        if (w1) begin
          a1 = 16'($urandom); b1 = 16'($urandom); c1 = 1'($urandom); sub1 = 1'($urandom); v1 = 1'b1;
        end else begin
          in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
          in_cin = 1'($urandom); in_sub = 1'($urandom); in_valid = 1'b1;
        end
        sent++;
      end
      if (w1) r1 = ($urandom_range(0, 2) != 0);
      else out_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    r1 = 1'b0; out_ready = 1'b0;
    checks++;
    if (((w1 ? pops1 : pops4) - p0) !== 200) begin
      fails++;
      $display("FAIL random_count(w1=%0d): got %0d completions in %0d cycles want 200",
               w1, (w1 ? pops1 : pops4) - p0, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_backpressure();
    test_reset_midop();
    test_single_word();
    test_random(1'b0);
    test_random(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
